// File: rtl/cla_multiword_sequencer_pkg.sv
// Shared types and defaults for the multi-word carry-look-ahead sequencer.
package cla_multiword_sequencer_pkg;

  localparam int unsigned DefaultWidth = 7;
  localparam int unsigned DefaultWords = 2;

  // Encoding 2'd3 is unused and recovers to StA.
  typedef enum logic [1:0] {
    StA   = 2'd0,
    StB   = 2'd1,
    StOut = 2'd2
  } seq_state_e;

endpackage

// File: rtl/carry_look_ahead.sv
// Combinational WIDTH-bit carry-look-ahead adder: {c, s} = a + b + y.
module carry_look_ahead #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y,
  output logic             c,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   cy;
  logic             acc;
  logic             term;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flat sum-of-products over generate/propagate terms,
  // not a ripple of the previous carry.
  always_comb begin
    cy   = '0;
    acc  = 1'b0;
    term = 1'b0;
    cy[0] = y;
    for (int i = 0; i < int'(WIDTH); i++) begin
      acc = y;
      for (int j = 0; j <= i; j++) begin
        acc = acc & p[j];
      end
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int j = k + 1; j <= i; j++) begin
          term = term & p[j];
        end
        acc = acc | term;
      end
      cy[i+1] = acc;
    end
  end

  assign s = p ^ cy[WIDTH-1:0];
  assign c = cy[WIDTH];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Streams two multi-word operands (LS word first, A then B) through one shared
// carry-look-ahead adder, chaining the carry between words.
module cla_multiword_sequencer
  import cla_multiword_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned WORDS = DefaultWords
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_carry
);

  localparam int unsigned CntW = $clog2(WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS - 1);

  seq_state_e      state_q, state_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  word_cnt_q, word_cnt_d;

  logic             add_c;
  logic [WIDTH-1:0] add_s;
  logic             is_last;

  carry_look_ahead #(
    .WIDTH(WIDTH)
  ) u_cla (
    .a(reg_a_q),
    .b(reg_b_q),
    .y(carry_q),
    .c(add_c),
    .s(add_s)
  );

  assign is_last = (word_cnt_q == LastCnt);

  always_comb begin
    state_d    = state_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    carry_d    = carry_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      StA: begin
        if (in_valid) begin
          reg_a_d = in_data;
          state_d = StB;
        end
      end
      StB: begin
        if (in_valid) begin
          reg_b_d = in_data;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (is_last) begin
            carry_d    = 1'b0;
            word_cnt_d = '0;
          end else begin
            carry_d    = add_c;
            word_cnt_d = word_cnt_q + CntW'(1);
          end
          state_d = StA;
        end
      end
      default: state_d = StA;
    endcase
    // Abort discards any handshake that coincides with it.
    if (clr) begin
      state_d    = StA;
      reg_a_d    = reg_a_q;
      reg_b_d    = reg_b_q;
      carry_d    = 1'b0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StA;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      carry_q    <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      carry_q    <= carry_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    in_ready  = ~rst & ((state_q == StA) | (state_q == StB));
    out_valid = ~rst & (state_q == StOut);
    out_data  = add_s;
    out_last  = (state_q == StOut) & is_last;
    out_carry = out_last & add_c;
  end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Scoreboard bench for cla_multiword_sequencer with WIDTH=7, WORDS=2.
module tb_cla_multiword_sequencer;

  localparam int unsigned W = 7;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         carry;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_last, out_carry;
  logic [W-1:0] out_data;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  cla_multiword_sequencer #(
    .WIDTH(7),
    .WORDS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hdead);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_last", 32'(out_last), 32'(mon_e.last));
        check("out_carry", 32'(out_carry), 32'(mon_e.carry));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(n), 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_txn(input logic [W-1:0] a0, a1, b0, b1);
    logic [2*W:0] tot;
    exp_t e;
    tot = {1'b0, a1, a0} + {1'b0, b1, b0};
    e.data = tot[W-1:0];     e.last = 1'b0; e.carry = 1'b0; sb.push_back(e);
    e.data = tot[2*W-1:W];   e.last = 1'b1; e.carry = tot[2*W]; sb.push_back(e);
  endtask

  task automatic run_txn(input logic [W-1:0] a0, a1, b0, b1);
    push_txn(a0, a1, b0, b1);
    send(a0);
    send(b0);
    send(a1);
    send(b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_data", 32'(out_data), 32'd0);
    check("post_rst_out_last", 32'(out_last), 32'd0);
    check("post_rst_out_carry", 32'(out_carry), 32'd0);

    // Carry chain, then zeros to show no carry leaks across transactions.
    run_txn(7'h7f, 7'h7f, 7'h01, 7'h00);
    run_txn(7'h00, 7'h00, 7'h00, 7'h00);
    run_txn(7'h05, 7'h00, 7'h03, 7'h00);
    drain();

    // Backpressure on word 0.
    out_ready = 1'b0;
    e.data = 7'h32; e.last = 1'b0; e.carry = 1'b0; sb.push_back(e);
    send(7'h10);
    send(7'h22);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_data", 32'(out_data), 32'h32);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_accepted", 32'({in_ready, out_valid}), 32'b10);
    e.data = 7'h00; e.last = 1'b1; e.carry = 1'b0; sb.push_back(e);
    send(7'h00);
    send(7'h00);
    drain();

    // Abort in S_B of word 1 after a carry-producing word 0.
    e.data = 7'h00; e.last = 1'b0; e.carry = 1'b0; sb.push_back(e);
    send(7'h7f);
    send(7'h01);
    send(7'h05);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'd1);
    run_txn(7'h01, 7'h00, 7'h01, 7'h00);
    drain();

    // Abort coincident with an output handshake: the word must not advance.
    out_ready = 1'b0;
    send(7'h03);
    send(7'h04);
    check("clr_hs_pending", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    run_txn(7'h01, 7'h00, 7'h02, 7'h00);
    drain();

    // Reset while in S_OUT.
    out_ready = 1'b0;
    send(7'h11);
    send(7'h22);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_release_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    run_txn(7'h40, 7'h7f, 7'h40, 7'h00);
    drain();

    for (int i = 0; i < 4; i++) begin
      run_txn(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
    end
    drain();
    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
